// File: rtl/mycpu_pkg.sv
// Shared CPU constants and the writeback request bundle.
// Used by the writeback arbiter and its bench.
package mycpu_pkg;

  localparam int XLEN       = 32;
  localparam int REG_ADDR_W = 5;

  typedef struct packed {
    logic [REG_ADDR_W-1:0] rd;
    logic [XLEN-1:0]       data;
  } wb_req_t;

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin picker: scans upward from ptr,
// first requester wins; returns one-hot grant and its index.
module rr_arbiter #(
  parameter int N  = 3,
  parameter int IW = 2
) (
  input  logic [N-1:0]  req,
  input  logic [IW-1:0] ptr,
  output logic [N-1:0]  gnt,
  output logic [IW-1:0] idx,
  output logic          any
);

  function automatic logic [IW-1:0] wrap(
    input logic [IW-1:0] p,
    input int            i
  );
    int c;
    c = int'(p) + i;
    if (c >= N) c = c - N;
    return c[IW-1:0];
  endfunction

  // first valid requester at or after ptr, modulo N
  always_comb begin
    gnt = '0;
    idx = '0;
    any = 1'b0;
    for (int i = 0; i < N; i++) begin
      if (!any && req[wrap(ptr, i)]) begin
        any      = 1'b1;
        idx      = wrap(ptr, i);
        gnt[idx] = 1'b1;
      end
    end
  end

endmodule

// File: rtl/rf_wb_arbiter.sv
// Shares the regfile write port between writeback sources,
// round-robin, with a registered single-cycle output stage.
module rf_wb_arbiter #(
  parameter int NUM_SRC = 3,
  parameter int XLEN    = mycpu_pkg::XLEN,
  parameter int AW      = mycpu_pkg::REG_ADDR_W
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    hold_i,
  input  logic [NUM_SRC-1:0]      req_valid_i,
  input  logic [NUM_SRC*AW-1:0]   req_addr_i,
  input  logic [NUM_SRC*XLEN-1:0] req_data_i,
  output logic [NUM_SRC-1:0]      req_ready_o,
  output logic                    rf_we_o,
  output logic [AW-1:0]           rf_waddr_o,
  output logic [XLEN-1:0]         rf_wdata_o,
  output logic                    busy_o
);

  import mycpu_pkg::*;

  localparam int IW = (NUM_SRC > 1) ? $clog2(NUM_SRC) : 1;

  logic [IW-1:0]      ptr;
  logic [IW-1:0]      idx;
  logic [NUM_SRC-1:0] gnt;
  logic [NUM_SRC-1:0] req;
  logic               hs;
  wb_req_t            sel;

  // ready is forced low during hold and while reset is asserted
  assign req = req_valid_i & {NUM_SRC{~hold_i & ~rst}};

  rr_arbiter #(
    .N  (NUM_SRC),
    .IW (IW)
  ) u_rr (
    .req (req),
    .ptr (ptr),
    .gnt (gnt),
    .idx (idx),
    .any (hs)
  );

  assign req_ready_o = gnt;
  assign sel.rd      = req_addr_i[idx*AW +: AW];
  assign sel.data    = req_data_i[idx*XLEN +: XLEN];
  assign busy_o      = rf_we_o;

  // priority moves just past the source that completed a handshake
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ptr <= '0;
    end else if (hs) begin
      ptr <= (idx == IW'(NUM_SRC - 1)) ? '0 : idx + 1'b1;
    end
  end

  // output stage: capture the winner; x0 consumes a turn but never writes
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rf_we_o    <= 1'b0;
      rf_waddr_o <= '0;
      rf_wdata_o <= '0;
    end else if (!hold_i) begin
      if (hs && (sel.rd != '0)) begin
        rf_we_o    <= 1'b1;
        rf_waddr_o <= sel.rd;
        rf_wdata_o <= sel.data;
      end else begin
        rf_we_o    <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_rf_wb_arbiter.sv
// Self-checking bench for rf_wb_arbiter: directed scenarios
// plus random traffic against a queue-free behavioural model.
module tb_rf_wb_arbiter;

  localparam int N = 3;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          hold = 1'b0;
  logic [N-1:0]  vld = '0;
  logic [4:0]    ad [N];
  logic [31:0]   dt [N];
  logic [N*5-1:0]  req_addr;
  logic [N*32-1:0] req_data;

  logic [N-1:0]  req_ready_o;
  logic          rf_we_o;
  logic [4:0]    rf_waddr_o;
  logic [31:0]   rf_wdata_o;
  logic          busy_o;

  int checks = 0;
  int errors = 0;

  int          m_ptr;
  logic        m_we;
  logic [4:0]  m_addr;
  logic [31:0] m_data;
  logic [31:0] rf_m [32];
  logic [31:0] rf_d [32];
  logic [N-1:0] eg;
  logic [N-1:0] g;

  always #5 clk = ~clk;

  // flatten per-source stimulus onto the DUT buses
  always_comb begin
    req_addr = '0;
    req_data = '0;
    for (int i = 0; i < N; i++) begin
      req_addr[i*5 +: 5]   = ad[i];
      req_data[i*32 +: 32] = dt[i];
    end
  end

  rf_wb_arbiter #(.NUM_SRC(N), .XLEN(32), .AW(5)) dut (
    .clk         (clk),
    .rst         (rst),
    .hold_i      (hold),
    .req_valid_i (vld),
    .req_addr_i  (req_addr),
    .req_data_i  (req_data),
    .req_ready_o (req_ready_o),
    .rf_we_o     (rf_we_o),
    .rf_waddr_o  (rf_waddr_o),
    .rf_wdata_o  (rf_wdata_o),
    .busy_o      (busy_o)
  );

  task automatic chk(input string nm, input logic [63:0] act,
                     input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  function automatic logic [N-1:0] exp_gnt();
    logic [N-1:0] r;
    r = '0;
    for (int k = 0; k < N; k++) begin
      int s;
      s = (m_ptr + k) % N;
      if (vld[s] && r == '0) r[s] = 1'b1;
    end
    return r;
  endfunction

  // per-cycle compare against the model, then advance the model
  always @(negedge clk) begin
    if (rst) begin
      chk("rst_ready", req_ready_o, '0);
      chk("rst_we", rf_we_o, 1'b0);
      chk("rst_addr", rf_waddr_o, 5'd0);
      chk("rst_data", rf_wdata_o, 32'd0);
      chk("rst_busy", busy_o, 1'b0);
      m_ptr  = 0;
      m_we   = 1'b0;
      m_addr = '0;
      m_data = '0;
      for (int r = 0; r < 32; r++) begin
        rf_m[r] = '0;
        rf_d[r] = '0;
      end
    end else begin
      eg = hold ? '0 : exp_gnt();
      chk("ready", req_ready_o, eg);
      chk("we", rf_we_o, m_we);
      chk("waddr", rf_waddr_o, m_addr);
      chk("wdata", rf_wdata_o, m_data);
      chk("busy", busy_o, m_we);
      if (rf_we_o) rf_d[rf_waddr_o] = rf_wdata_o;
      if (!hold) begin
        m_we = 1'b0;
        for (int s = 0; s < N; s++) begin
          if (eg[s]) begin
            m_ptr = (s + 1) % N;
            if (ad[s] != 5'd0) begin
              m_we        = 1'b1;
              m_addr      = ad[s];
              m_data      = dt[s];
              rf_m[ad[s]] = dt[s];
            end
          end
        end
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    for (int i = 0; i < N; i++) begin
      ad[i] = '0;
      dt[i] = '0;
    end
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;

    // round-robin with all sources valid
    step();
    vld = 3'b111;
    ad[0] = 5'd1; dt[0] = 32'h1111_0001;
    ad[1] = 5'd2; dt[1] = 32'h2222_0002;
    ad[2] = 5'd3; dt[2] = 32'h3333_0003;
    for (int k = 0; k < 6; k++) begin
      #1;
      chk("t3_order", req_ready_o, 3'b001 << (k % 3));
      if (k > 0) chk("t3_waddr", rf_waddr_o, 5'(((k - 1) % 3) + 1));
      step();
    end
    vld = '0;
    #1;
    chk("t3_last_waddr", rf_waddr_o, 5'd3);
    chk("t3_last_we", rf_we_o, 1'b1);

    // x0 request consumes its turn without a write
    vld = 3'b001; ad[0] = 5'd0; dt[0] = 32'h1234;
    #1 chk("t4_ready", req_ready_o, 3'b001);
    step();
    vld = 3'b011; ad[0] = 5'd4; dt[0] = 32'h4444; ad[1] = 5'd6;
    #1;
    chk("t4_no_write", rf_we_o, 1'b0);
    chk("t4_ptr_adv", req_ready_o, 3'b010);
    step();

    // hold keeps the pending write on the port
    vld = 3'b101; ad[2] = 5'd7; dt[2] = 32'hCAFE_0007;
    #1;
    chk("t5_ready", req_ready_o, 3'b100);
    chk("t5_prev_waddr", rf_waddr_o, 5'd6);
    step();
    hold = 1'b1; vld = 3'b001;
    for (int k = 0; k < 3; k++) begin
      #1;
      chk("t5_hold_we", rf_we_o, 1'b1);
      chk("t5_hold_addr", rf_waddr_o, 5'd7);
      chk("t5_hold_ready", req_ready_o, 3'b000);
      step();
    end
    hold = 1'b0;
    #1;
    chk("t5_resume", req_ready_o, 3'b001);
    chk("t5_still_7", rf_waddr_o, 5'd7);
    step();
    vld = '0;
    #1 chk("t5_src0_write", rf_waddr_o, 5'd4);

    // single source, then async reset mid-stream
    vld = 3'b010; ad[1] = 5'd5; dt[1] = 32'hDEAD_BEEF;
    #1 chk("t2_ready", req_ready_o, 3'b010);
    step();
    vld = '0;
    #1;
    chk("t2_we", rf_we_o, 1'b1);
    chk("t2_addr", rf_waddr_o, 5'd5);
    chk("t2_data", rf_wdata_o, 32'hDEAD_BEEF);
    step();
    #1 chk("t2_we_off", rf_we_o, 1'b0);
    vld = 3'b010; ad[1] = 5'd8; dt[1] = 32'h8888;
    step();
    vld = 3'b001;
    #1 rst = 1'b1;
    #1;
    chk("t1_we", rf_we_o, 1'b0);
    chk("t1_addr", rf_waddr_o, 5'd0);
    chk("t1_data", rf_wdata_o, 32'd0);
    chk("t1_ready", req_ready_o, 3'b000);
    step();
    step();
    rst = 1'b0;

    // conflict on x9 right after reset: src0 first, src2 last
    vld = 3'b101;
    ad[0] = 5'd9; dt[0] = 32'hAAAA_AAAA;
    ad[2] = 5'd9; dt[2] = 32'hBBBB_BBBB;
    #1 chk("t1_first_grant", req_ready_o, 3'b001);
    step();
    vld = 3'b100;
    #1;
    chk("t6_ready2", req_ready_o, 3'b100);
    chk("t6_wdata_a", rf_wdata_o, 32'hAAAA_AAAA);
    step();
    vld = '0;
    #1 chk("t6_wdata_b", rf_wdata_o, 32'hBBBB_BBBB);
    step();
    step();
    chk("t6_final_x9", rf_d[9], 32'hBBBB_BBBB);

    // random traffic; an ungranted request holds its payload
    for (int c = 0; c < 400; c++) begin
      @(negedge clk);
      g = req_ready_o & vld;
      @(posedge clk);
      #1;
      for (int s = 0; s < N; s++) begin
        if (!(vld[s] && !g[s])) begin
          vld[s] = ($urandom_range(0, 99) < 60);
          ad[s]  = ($urandom_range(0, 9) == 0) ? 5'd0 : 5'($urandom);
          dt[s]  = $urandom;
        end
      end
      hold = ($urandom_range(0, 99) < 15);
    end
    vld  = '0;
    hold = 1'b0;
    repeat (3) step();
    for (int r = 0; r < 32; r++) begin
      chk("rf_final", rf_d[r], rf_m[r]);
    end
    chk("x0_untouched", rf_d[0], 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
